pipelined_addsub: RTL and testbench

- Parametrised, pipelined successor to the team's flat 16-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands with carry/borrow-in.
- Carry chain is split into STAGES registered chunks so wide datapaths close timing.
- Valid/ready handshake on both sides; reports carry-out and signed overflow; sits between operand sources and ALU result muxing.

---
 rtl/pipelined_addsub_if.sv | 30 +++
 rtl/pipelined_addsub.sv | 109 ++++++++++
 tb/tb_pipelined_addsub.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// Latency: none, wiring only.
// Backpressure: in_ready/out_ready carry flow control in each direction.
interface pipelined_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Operand source / result sink side.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // Arithmetic block side.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract with carry/borrow-in, carry-out and signed overflow.
// Latency: STAGES cycles from accept to out_valid; one beat per cycle throughput.
// Backpressure: whole pipe stalls while the last stage holds an unconsumed result; in_ready follows.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_addsub_if.slave bus
);
    // WIDTH must be a multiple of STAGES; each stage resolves one CHUNK of the carry chain.
    localparam int CHUNK = WIDTH / STAGES;

    logic             advance;
    logic [WIDTH-1:0] beff;
    logic             ceff;

    // Stage registers. xw holds resolved sum chunks below the stage boundary and the
    // still-unresolved A chunks above it. bw holds the unresolved B chunks right-aligned,
    // so the next stage always finds its B chunk in the low bits.
    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  xw [STAGES];
    logic [WIDTH-1:0]  bw [STAGES];
    logic              cy [STAGES];
    logic              ovf_q;

    // Next-state values produced by each stage's chunk adder.
    logic              nx_v [STAGES];
    logic [WIDTH-1:0]  nx_x [STAGES];
    logic [WIDTH-1:0]  nx_b [STAGES];
    logic              nx_c [STAGES];
    logic              nx_ovf;

    // Subtraction is A + ~B + ~borrow; the inversion is applied once at the input.
    assign beff = bus.sub ? ~bus.b : bus.b;
    assign ceff = bus.cin ^ bus.sub;

    // All stages move in lock step; only a stalled full last stage freezes the pipe.
    assign advance      = ~vld[STAGES-1] | bus.out_ready;
    assign bus.in_ready = advance;

    assign bus.out_valid = vld[STAGES-1];
    assign bus.sum       = xw[STAGES-1];
    assign bus.cout      = cy[STAGES-1];
    assign bus.ovf       = ovf_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int               LSB   = k * CHUNK;
        localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}}) << LSB;

        logic             src_v;
        logic             src_c;
        logic [WIDTH-1:0] src_x;
        logic [WIDTH-1:0] src_b;
        logic [CHUNK:0]   part;

        if (k == 0) begin : g_head
            assign src_v = bus.in_valid;
            assign src_c = ceff;
            assign src_x = bus.a;
            assign src_b = beff;
        end else begin : g_body
            assign src_v = vld[k-1];
            assign src_c = cy[k-1];
            assign src_x = xw[k-1];
            assign src_b = bw[k-1];
        end

        assign part    = {1'b0, src_x[LSB +: CHUNK]} + {1'b0, src_b[CHUNK-1:0]}
                       + (CHUNK+1)'(src_c);
        assign nx_v[k] = src_v;
        assign nx_c[k] = part[CHUNK];
        assign nx_x[k] = (src_x & ~CMASK) | (WIDTH'(part[CHUNK-1:0]) << LSB);
        assign nx_b[k] = src_b >> CHUNK;

        if (k == STAGES - 1) begin : g_tail
            // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
            assign nx_ovf = part[CHUNK] ^ (part[CHUNK-1] ^ src_x[WIDTH-1] ^ src_b[CHUNK-1]);
        end
    end

    // Shift the whole pipe on advance; data registers only load behind a valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                xw[k] <= '0;
                bw[k] <= '0;
                cy[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                vld[k] <= nx_v[k];
                if (nx_v[k]) begin
                    xw[k] <= nx_x[k];
                    cy[k] <= nx_c[k];
                    if (k < STAGES - 1) begin
                        bw[k] <= nx_b[k];
                    end
                end
            end
            if (nx_v[STAGES-1]) begin
                ovf_q <= nx_ovf;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed cases on a 16/4 instance plus randomized
// traffic on 16/1, 32/8 and 64/4 instances against an arithmetic reference model.
module tb_pipelined_addsub;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-instance stimulus and observation, index 0..3.
    logic        iv   [4];
    logic [63:0] ia   [4];
    logic [63:0] ib   [4];
    logic        icin [4];
    logic        isub [4];
    logic        ordy [4];
    logic        ir   [4];
    logic        ov   [4];
    logic [63:0] os   [4];
    logic        oc   [4];
    logic        oo   [4];

    int          send_left [4];
    int          pin       [4];
    int          prdy      [4];
    int          consumed  [4];
    logic        held      [4];
    logic        acc       [4];
    logic [65:0] hold_val  [4];
    logic [65:0] expq      [4][$];
    int          zero_rdy0;

    function automatic int wid(int i);
        return (i == 2) ? 32 : (i == 3) ? 64 : 16;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = (g == 2) ? 32 : (g == 3) ? 64 : 16;
        localparam int S = (g == 1) ? 1 : (g == 2) ? 8 : 4;
        pipelined_addsub_if #(.WIDTH(W)) bus ();
        assign bus.in_valid  = iv[g];
        assign bus.a         = ia[g][W-1:0];
        assign bus.b         = ib[g][W-1:0];
        assign bus.cin       = icin[g];
        assign bus.sub       = isub[g];
        assign bus.out_ready = ordy[g];
        assign ir[g]         = bus.in_ready;
        assign ov[g]         = bus.out_valid;
        assign os[g]         = 64'(bus.sum);
        assign oc[g]         = bus.cout;
        assign oo[g]         = bus.ovf;
        pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    // Reference: exact integer arithmetic; returns {ovf, cout, sum}.
    function automatic logic [65:0] ref_model(int w, logic [63:0] a, logic [63:0] b,
                                              logic cin, logic sub);
        logic [63:0]        m;
        logic [67:0]        ru;
        logic [67:0]        upow;
        logic signed [67:0] pow, half, sa, sb, sc, rs;
        logic               cout, ovf;
        m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        a    = a & m;
        b    = b & m;
        upow = 68'd1 << w;
        ru   = sub ? ({4'b0, a} - {4'b0, b} - 68'(cin) + upow)
                   : ({4'b0, a} + {4'b0, b} + 68'(cin));
        cout = ru[w];
        pow  = $signed(upow);
        half = pow >>> 1;
        sa   = $signed({4'b0, a});
        sb   = $signed({4'b0, b});
        if (a[w-1]) sa = sa - pow;
        if (b[w-1]) sb = sb - pow;
        sc   = cin ? 68'sd1 : 68'sd0;
        rs   = sub ? (sa - sb - sc) : (sa + sb + sc);
        ovf  = (rs < -half) || (rs >= half);
        return {ovf, cout, ru[63:0] & m};
    endfunction

    function automatic logic [63:0] pick(int w);
        case ($urandom_range(5))
            0:       return {64{1'b1}};
            1:       return 64'd1 << (w - 1);
            2:       return (64'd1 << (w - 1)) - 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic check(string tag, logic [65:0] obs, logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One directed beat on the 16/4 instance; checks exact latency and one-cycle output.
    task automatic single_op(string tag, logic [63:0] a, logic [63:0] b, logic cin, logic sub,
                             logic [63:0] es, logic ec, logic eo);
        iv[0] = 1'b1; ia[0] = a; ib[0] = b; icin[0] = cin; isub[0] = sub; ordy[0] = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 66'(ir[0]), 66'd1);
        @(posedge clk); #1;
        iv[0] = 1'b0; ia[0] = {$urandom, $urandom}; ib[0] = {$urandom, $urandom};
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("%s_valid_c%0d", tag, c), 66'(ov[0]), 66'(c == 4));
            if (c == 4) begin
                check({tag, "_sum"},  66'(os[0]), 66'(es));
                check({tag, "_cout"}, 66'(oc[0]), 66'(ec));
                check({tag, "_ovf"},  66'(oo[0]), 66'(eo));
            end
            @(posedge clk); #1;
        end
    endtask

    // Cycle engine: random sources/sinks on every instance with a scoreboard per instance.
    // Instance 0 has out_ready forced low for engine cycles lo..hi when lo >= 0.
    task automatic run(int n, int lo, int hi);
        logic [65:0] e;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!iv[i] && send_left[i] > 0 && $urandom_range(99) < pin[i]) begin
                    iv[i]   = 1'b1;
                    ia[i]   = pick(wid(i));
                    ib[i]   = pick(wid(i));
                    icin[i] = 1'($urandom_range(1));
                    isub[i] = 1'($urandom_range(1));
                end
                ordy[i] = ($urandom_range(99) < prdy[i]);
            end
            if (lo >= 0 && c >= lo && c <= hi) ordy[0] = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("in_ready[%0d]", i), 66'(ir[i]), 66'(!(ov[i] && !ordy[i])));
                if (i == 0 && lo >= 0 && c >= lo && c <= hi && !ir[0]) zero_rdy0++;
                if (ov[i] && held[i])
                    check($sformatf("hold[%0d]", i), {oo[i], oc[i], os[i]}, hold_val[i]);
                if (ov[i] && ordy[i]) begin
                    if (expq[i].size() == 0) begin
                        check($sformatf("spurious[%0d]", i), 66'(ov[i]), 66'd0);
                    end else begin
                        e = expq[i].pop_front();
                        check($sformatf("sum[%0d]", i),  66'(os[i]), 66'(e[63:0]));
                        check($sformatf("cout[%0d]", i), 66'(oc[i]), 66'(e[64]));
                        check($sformatf("ovf[%0d]", i),  66'(oo[i]), 66'(e[65]));
                        consumed[i]++;
                    end
                end
                held[i]     = ov[i] && !ordy[i];
                hold_val[i] = {oo[i], oc[i], os[i]};
                acc[i]      = iv[i] && ir[i];
                if (acc[i]) begin
                    expq[i].push_back(ref_model(wid(i), ia[i], ib[i], icin[i], isub[i]));
                    send_left[i]--;
                end
            end
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) if (acc[i]) iv[i] = 1'b0;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0; ia[i] = '0; ib[i] = '0; icin[i] = 1'b0; isub[i] = 1'b0;
            ordy[i] = 1'b1; send_left[i] = 0; pin[i] = 0; prdy[i] = 100;
            consumed[i] = 0; held[i] = 1'b0; acc[i] = 1'b0; hold_val[i] = '0;
        end
        zero_rdy0 = 0;

        // Reset state.
        #12;
        check("rst_sum",  66'(os[0]), 66'd0);
        check("rst_cout", 66'(oc[0]), 66'd0);
        check("rst_ovf",  66'(oo[0]), 66'd0);
        for (int i = 0; i < 4; i++) check($sformatf("rst_valid[%0d]", i), 66'(ov[i]), 66'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        ordy[0] = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_rst", 66'(ir[0]), 66'd1);
        ordy[0] = 1'b1;

        // Directed arithmetic cases.
        single_op("add_wrap", 64'hFFFF, 64'h0001, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b0);
        single_op("add_ovf",  64'h7FFF, 64'h0001, 1'b0, 1'b0, 64'h8000, 1'b0, 1'b1);
        single_op("add_cin",  64'h1234, 64'h4321, 1'b1, 1'b0, 64'h5556, 1'b0, 1'b0);
        single_op("sub_neg",  64'h0005, 64'h0007, 1'b0, 1'b1, 64'hFFFE, 1'b0, 1'b0);
        single_op("sub_ovf",  64'h8000, 64'h0001, 1'b0, 1'b1, 64'h7FFF, 1'b1, 1'b1);

        // Eight back-to-back beats with the sink stalled on cycles 6-9.
        send_left[0] = 8; pin[0] = 100; consumed[0] = 0; zero_rdy0 = 0;
        run(20, 6, 9);
        check("stall_results",      66'(consumed[0]), 66'd8);
        check("stall_in_ready_low", 66'(zero_rdy0), 66'd4);
        check("stall_queue_empty",  66'(expq[0].size()), 66'd0);

        // Reset with three beats in flight and the oldest parked at the output.
        ordy[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[0] = 1'b1; ia[0] = {$urandom, $urandom}; ib[0] = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        @(posedge clk); #1;
        check("midrst_full", 66'(ov[0]), 66'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid_now", 66'(ov[0]), 66'd0);
        check("midrst_sum_now",   66'(os[0]), 66'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        ordy[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("midrst_no_stale_%0d", k), 66'(ov[0]), 66'd0);
        end
        @(posedge clk); #1;
        single_op("post_rst", 64'h0001, 64'h0002, 1'b0, 1'b0, 64'h0003, 1'b0, 1'b0);

        // Randomized regression on all four configurations.
        for (int i = 0; i < 4; i++) begin
            send_left[i] = 250; pin[i] = 70; prdy[i] = 60; consumed[i] = 0; held[i] = 1'b0;
        end
        run(800, -1, -1);
        for (int i = 0; i < 4; i++) prdy[i] = 100;
        for (int t = 0; t < 400; t++) begin
            busy = 0;
            for (int i = 0; i < 4; i++)
                if (send_left[i] > 0 || expq[i].size() > 0 || iv[i]) busy++;
            if (busy == 0) break;
            run(1, -1, -1);
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rand_sent[%0d]", i),     66'(send_left[i]), 66'd0);
            check($sformatf("rand_pending[%0d]", i),  66'(expq[i].size()), 66'd0);
            check($sformatf("rand_consumed[%0d]", i), 66'(consumed[i]), 66'd250);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
